// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// default geometry.
package seq_pkg;

  // Default pattern width and repeat/pair-counter width.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CW    = 4;

  // Transmitter control states; the encoding is fixed so other blocks can
  // decode it directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pair_counter.sv
// Saturating counter of adjacent 1-1 pairs in a serial bit stream. It behaves
// like the downstream "11" sequence detector: a bit counts only when it is 1
// and the previous valid bit since the last clear was also 1.
module pair_counter #(
  parameter int CW = seq_pkg::DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_bit,
  input  logic          i_valid,
  input  logic          i_clear,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] MAX_COUNT = {CW{1'b1}};

  logic          r_prev;
  logic [CW-1:0] r_count;

  // Track the previous emitted bit and count 1-1 pairs, saturating at max.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees pre-edge values of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else if (i_clear) begin
      // A fresh transfer has no predecessor bit.
      r_prev  <= 1'b0;
      r_count <= '0;
    end else if (i_valid) begin
      r_prev <= i_bit;
      if (i_bit && r_prev && (r_count != MAX_COUNT)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB first, repeated
// back to back a programmable number of times, and counts the 1-1 pairs it
// emits for comparison against a downstream sequence detector.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    reps,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    pairs
);

  // Bit index within one copy runs 0..WIDTH-1; sized so it can hold WIDTH.
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic [BW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_copy_cnt;

  logic w_accept;
  logic w_last_bit;
  logic w_last_copy;

  assign w_accept    = (r_state == IDLE) && load;
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_last_copy = (r_copy_cnt == CW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; w is forced low whenever valid is low.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w            = 1'b0;
    valid        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) w_next_state = SHIFT;
      end
      SHIFT: begin
        w     = r_shreg[WIDTH-1];
        valid = 1'b1;
        busy  = 1'b1;
        if (w_last_bit && w_last_copy) w_next_state = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Capture the request, then shift MSB first and reload for each copy.
  // NOTE: the shift register and pattern copy are ordinary flops, so they are
  // cleared by reset along with the counters; nothing stale survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg    <= '0;
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_copy_cnt <= '0;
    end else if (w_accept) begin
      r_shreg    <= data;
      r_data     <= data;
      r_bit_cnt  <= '0;
      // A repeat count of zero still sends one copy.
      r_copy_cnt <= (reps == '0) ? CW'(1) : reps;
    end else if (r_state == SHIFT) begin
      if (w_last_bit) begin
        // Next copy starts at the MSB in the very next cycle.
        r_shreg    <= r_data;
        r_bit_cnt  <= '0;
        r_copy_cnt <= r_copy_cnt - 1'b1;
      end else begin
        r_shreg   <= r_shreg << 1;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  pair_counter #(
    .CW(CW)
  ) u_pair_counter (
    .clk    (clk),
    .rst    (rst),
    .i_bit  (w),
    .i_valid(valid),
    .i_clear(w_accept),
    .o_count(pairs)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: streams, pair counts, saturation, load
// blocking while busy, and asynchronous abort.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] data;
  logic [3:0] reps;
  logic       w;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] pairs;

  int n_checks;
  int n_errors;

  seq_pattern_tx #(
    .WIDTH(8),
    .CW   (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (data),
    .reps (reps),
    .w    (w),
    .valid(valid),
    .busy (busy),
    .done (done),
    .pairs(pairs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present a load for one accepting edge; returns just after that edge,
  // i.e. at the start of the first SHIFT cycle.
  task automatic start(input logic [7:0] d, input logic [3:0] r);
    @(posedge clk);
    #1;
    load = 1'b1;
    data = d;
    reps = r;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Check nbits of pattern pat (MSB first, repeating), the DONE cycle and the
  // return to IDLE. With glitch set, load is pulsed with data 0 mid-stream
  // and again in the DONE cycle; neither may disturb anything.
  task automatic run_xfer(input string name, input logic [7:0] pat, input logic [3:0] r,
                          input int nbits, input logic [3:0] exp_pairs, input bit glitch);
    start(pat, r);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      check($sformatf("%s w[%0d]", name, i), 32'(w), 32'(pat[7 - (i % 8)]));
      check($sformatf("%s valid[%0d]", name, i), 32'(valid), 32'd1);
      if (i == 0) check({name, " pairs cleared"}, 32'(pairs), 32'd0);
      if (glitch && i == 3) begin
        load = 1'b1;
        data = 8'h00;
        reps = 4'd0;
      end
      if (glitch && i == 4) load = 1'b0;
    end
    @(negedge clk);
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " done valid"}, 32'(valid), 32'd0);
    check({name, " done w"}, 32'(w), 32'd0);
    check({name, " done busy"}, 32'(busy), 32'd1);
    check({name, " pairs"}, 32'(pairs), 32'(exp_pairs));
    if (glitch) begin
      load = 1'b1;
      data = 8'h00;
    end
    @(negedge clk);
    load = 1'b0;
    check({name, " idle done"}, 32'(done), 32'd0);
    check({name, " idle busy"}, 32'(busy), 32'd0);
    check({name, " idle valid"}, 32'(valid), 32'd0);
    @(negedge clk);
    check({name, " still idle"}, 32'(busy), 32'd0);
    check({name, " pairs hold"}, 32'(pairs), 32'(exp_pairs));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    load = 1'b0;
    data = 8'h00;
    reps = 4'd0;

    #2;
    check("reset w", 32'(w), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset pairs", 32'(pairs), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1011_0110: pairs at bits 2-3 and 5-6.
    run_xfer("b6x1", 8'hB6, 4'd1, 8, 4'd2, 1'b0);
    // 1000_0001 twice: only the copy-boundary pair counts.
    run_xfer("81x2", 8'h81, 4'd2, 16, 4'd1, 1'b0);
    // reps=0 sends one copy; no pairs.
    run_xfer("81x0", 8'h81, 4'd0, 8, 4'd0, 1'b0);
    // 16 ones -> 15 pairs.
    run_xfer("ffx2", 8'hFF, 4'd2, 16, 4'd15, 1'b0);
    // 24 ones -> 23 pairs, saturates at 15.
    run_xfer("ffx3", 8'hFF, 4'd3, 24, 4'd15, 1'b0);
    // Alternating bits -> no pairs.
    run_xfer("aax1", 8'hAA, 4'd1, 8, 4'd0, 1'b0);
    // Loads during the transfer and in DONE are ignored.
    run_xfer("b6glitch", 8'hB6, 4'd1, 8, 4'd2, 1'b1);

    // Abort an all-ones transfer at bit 4.
    start(8'hFF, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort w[%0d]", i), 32'(w), 32'd1);
    end
    @(negedge clk);
    check("abort pre w4", 32'(w), 32'd1);
    rst = 1'b1;
    #1;
    check("abort w", 32'(w), 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort pairs", 32'(pairs), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort held done[%0d]", i), 32'(done), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("post abort done[%0d]", i), 32'(done), 32'd0);
      check($sformatf("post abort valid[%0d]", i), 32'(valid), 32'd0);
    end
    // 0000_0011 -> one pair.
    run_xfer("03x1", 8'h03, 4'd1, 8, 4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 8: pattern width in bits.
REQ-002 Parameter CW, default 4: width of the repeat field and of the pair counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 load  in  1  request to start a transfer; sampled only in IDLE.
REQ-006 data  in  WIDTH  pattern to transmit, MSB first; captured when load is accepted.
REQ-007 reps  in  CW  number of back-to-back pattern copies; captured when load is accepted.
REQ-008 w  out  1  serial bit stream, one bit per cycle, driving a serial sequence detector.
REQ-009 valid  out  1  high in every cycle in which w carries a pattern bit.
REQ-010 busy  out  1  high in SHIFT and DONE.
REQ-011 done  out  1  one-cycle pulse after the last bit.
REQ-012 pairs  out  CW  count of adjacent 1-1 bit pairs emitted in the current or last transfer; saturates.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with load=1, the block SHALL capture data and reps, clear pairs, and enter SHIFT on the next edge.
REQ-015 A reps value of 0 SHALL be treated as 1; the total transfer length SHALL be WIDTH*max(reps,1) bits.
REQ-016 In the first SHIFT cycle, w SHALL equal data[WIDTH-1] and valid=1 (latency of one cycle from load acceptance).
REQ-017 Each SHIFT cycle SHALL emit the next bit MSB first; after bit 0, the next copy SHALL begin at the MSB with no gap cycle.
REQ-018 After the final bit, the FSM SHALL enter DONE for exactly one cycle with done=1, valid=0 and w=0, then return to IDLE.
REQ-019 Whenever valid=0, w SHALL be 0.
REQ-020 pairs SHALL increment on each emitted bit that is 1 and whose preceding emitted bit in the same transfer was 1, including across copy boundaries.
REQ-021 The first bit of a transfer SHALL have no predecessor; a bit from a previous transfer SHALL never count.
REQ-022 pairs SHALL saturate at 2^CW-1 and SHALL hold its value after DONE until the next accepted load.
REQ-023 load SHALL be ignored while busy=1, including in the DONE cycle; data and reps changes during a transfer SHALL have no effect.
REQ-024 The bit counter and copy counter SHALL each be wide enough for WIDTH and 2^CW-1 respectively; neither SHALL wrap during a transfer.

Reset
REQ-025 Reset=1 SHALL immediately force IDLE, w=0, valid=0, busy=0, done=0 and pairs=0, and clear the shift register and counters.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; the next load after release SHALL start a fresh transfer.

Structure
REQ-027 The state encoding (IDLE=0, SHIFT=1, DONE=2) and the WIDTH/CW defaults SHALL live in the shared package seq_pkg.
REQ-028 Pair counting SHALL be a sub-module pair_counter (inputs: bit, valid, clear; output: saturating count) that mirrors the 1-1 detector behaviour.

Verification
REQ-029 load with data=8'hB6, reps=1 -> w=1,0,1,1,0,1,1,0 in cycles 1-8 with valid=1, done pulse in cycle 9, pairs=2.
REQ-030 data=8'h81, reps=2 -> 16 bits with the cross-boundary pair counted, pairs=1; data=8'h81, reps=0 -> 8 bits, pairs=0.
REQ-031 data=8'hFF, reps=2 -> pairs=15; data=8'hFF, reps=3 -> 24 ones, pairs saturates at 15.
REQ-032 load pulsed with data=8'h00 during an 8'hB6 transfer and in its DONE cycle -> stream and pairs unchanged (pairs=2), no restart.
REQ-033 Reset asserted at bit 4 of an 8'hFF transfer -> outputs 0 asynchronously, no done pulse; a subsequent 8'h03, reps=1 load -> pairs=1.
